axi_aw_router: RTL and testbench



---
 rtl/axi_router_pkg.sv | 45 ++++
 rtl/axi_aw_router_rr_arbiter.sv | 31 +++
 rtl/axi_aw_router.sv | 188 ++++++++++++++++++
 tb/tb_axi_aw_router.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_router_pkg.sv
// Shared types and the address map for the AXI write-address router.
package axi_router_pkg;

    localparam int PKG_NUM_S     = 5;
    localparam int PKG_ADDR_BITS = 32;
    localparam int PKG_ID_BITS   = 4;
    localparam int PKG_IDS_BITS  = 8;
    localparam int PKG_LEN_BITS  = 4;
    localparam int PKG_SIZE_BITS = 3;

    // Upper slave-side ID bits carry the index of the originating master.
    localparam int TAG_BITS    = PKG_IDS_BITS - PKG_ID_BITS;
    localparam int DEFAULT_SLV = PKG_NUM_S - 1;

    typedef logic [PKG_ADDR_BITS-1:0] addr_t;

    // Region map. The last slot is the default slave: its mask of zero
    // against an all-ones base can never match, so it is only reached on a miss.
    localparam addr_t SLV_BASE [PKG_NUM_S] = '{
        32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000, 32'hFFFF_FFFF
    };
    localparam addr_t SLV_MASK [PKG_NUM_S] = '{
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000, 32'hC000_0000, 32'h0000_0000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } aw_state_e;

    typedef struct packed {
        logic [PKG_IDS_BITS-1:0]  id;
        addr_t                    addr;
        logic [PKG_LEN_BITS-1:0]  len;
        logic [PKG_SIZE_BITS-1:0] size;
        logic [1:0]               burst;
    } aw_req_t;

    function automatic logic addr_hit(input addr_t a, input addr_t base, input addr_t mask);
        return ((a & mask) == base);
    endfunction

endpackage

// File: rtl/axi_aw_router_rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first requester at or
// after i_ptr+1 (mod NUM_M). The pointer itself is owned by the parent.
module rr_arbiter #(
    parameter int NUM_M    = 2,
    parameter int IDX_BITS = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0]    i_req,
    input  logic [IDX_BITS-1:0] i_ptr,
    output logic [NUM_M-1:0]    o_grant,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_any
);

    // Walk the masters in priority order starting just after the pointer.
    always_comb begin
        logic w_take;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_take  = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            for (int m = 0; m < NUM_M; m++) begin
                w_take     = !o_any && i_req[m] && (m == ((int'(i_ptr) + i) % NUM_M));
                o_grant[m] = o_grant[m] | w_take;
                o_idx      = w_take ? IDX_BITS'(m) : o_idx;
                o_any      = o_any | w_take;
            end
        end
    end

endmodule

// File: rtl/axi_aw_router.sv
// AXI write-address router: round-robin accept from NUM_M masters, decode to
// one of NUM_S slaves, and hold the write path until W and B have finished.
module axi_aw_router #(
    parameter int NUM_M       = 2,
    parameter int NUM_S       = 5,
    parameter int ID_BITS     = 4,
    parameter int IDS_BITS    = 8,
    parameter int ADDR_BITS   = 32,
    parameter int LEN_BITS    = 4,
    parameter int SIZE_BITS   = 3,
    parameter int DEFAULT_SLV = NUM_S - 1,
    localparam int MI_BITS    = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int SI_BITS    = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [NUM_M*ID_BITS-1:0]     AWID_M,
    input  logic [NUM_M*ADDR_BITS-1:0]   AWADDR_M,
    input  logic [NUM_M*LEN_BITS-1:0]    AWLEN_M,
    input  logic [NUM_M*SIZE_BITS-1:0]   AWSIZE_M,
    input  logic [NUM_M*2-1:0]           AWBURST_M,
    input  logic [NUM_M-1:0]             AWVALID_M,
    output logic [NUM_M-1:0]             AWREADY_M,
    output logic [NUM_S*IDS_BITS-1:0]    AWID_S,
    output logic [NUM_S*ADDR_BITS-1:0]   AWADDR_S,
    output logic [NUM_S*LEN_BITS-1:0]    AWLEN_S,
    output logic [NUM_S*SIZE_BITS-1:0]   AWSIZE_S,
    output logic [NUM_S*2-1:0]           AWBURST_S,
    output logic [NUM_S-1:0]             AWVALID_S,
    input  logic [NUM_S-1:0]             AWREADY_S,
    input  logic                         wlast_hs,
    input  logic                         b_hs,
    output logic                         wr_busy,
    output logic [MI_BITS-1:0]           w_mst,
    output logic [SI_BITS-1:0]           w_slv
);

    import axi_router_pkg::*;

    localparam int TAGW = IDS_BITS - ID_BITS;

    aw_state_e            r_state;
    logic [MI_BITS-1:0]   r_ptr;
    logic [MI_BITS-1:0]   r_mst;
    logic [SI_BITS-1:0]   r_slv;
    logic                 r_awvalid;
    aw_req_t              r_req;

    logic [NUM_M-1:0]     w_gnt;
    logic [MI_BITS-1:0]   w_gnt_idx;
    logic                 w_gnt_any;
    logic                 w_accept;
    logic                 w_aw_hs;
    logic [ID_BITS-1:0]   w_sel_id;
    logic [ADDR_BITS-1:0] w_sel_addr;
    logic [LEN_BITS-1:0]  w_sel_len;
    logic [SIZE_BITS-1:0] w_sel_size;
    logic [1:0]           w_sel_burst;
    logic [SI_BITS-1:0]   w_dec;

    rr_arbiter #(
        .NUM_M    (NUM_M),
        .IDX_BITS (MI_BITS)
    ) u_arb (
        .i_req   (AWVALID_M),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    // Select the winning master's AW fields.
    always_comb begin
        w_sel_id    = '0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_size  = '0;
        w_sel_burst = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (w_gnt_idx == MI_BITS'(m)) begin
                w_sel_id    = AWID_M[m*ID_BITS +: ID_BITS];
                w_sel_addr  = AWADDR_M[m*ADDR_BITS +: ADDR_BITS];
                w_sel_len   = AWLEN_M[m*LEN_BITS +: LEN_BITS];
                w_sel_size  = AWSIZE_M[m*SIZE_BITS +: SIZE_BITS];
                w_sel_burst = AWBURST_M[m*2 +: 2];
            end else begin
                w_sel_id = w_sel_id;
            end
        end
    end

    // Address decode; scanning downwards lets the lowest matching slave win.
    always_comb begin
        w_dec = SI_BITS'(DEFAULT_SLV);
        for (int s = NUM_S - 1; s >= 0; s--) begin
            w_dec = addr_hit(w_sel_addr, SLV_BASE[s], SLV_MASK[s]) ? SI_BITS'(s) : w_dec;
        end
    end

    // Accept only in IDLE and never while reset is being applied.
    always_comb begin
        if (ARESETn && (r_state == IDLE)) begin
            AWREADY_M = w_gnt;
            w_accept  = w_gnt_any;
        end else begin
            AWREADY_M = '0;
            w_accept  = 1'b0;
        end
    end

    // Drive the registered request onto the decoded slave only; others see zeros.
    always_comb begin
        AWVALID_S = '0;
        AWID_S    = '0;
        AWADDR_S  = '0;
        AWLEN_S   = '0;
        AWSIZE_S  = '0;
        AWBURST_S = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (ARESETn && r_awvalid && (r_slv == SI_BITS'(s))) begin
                AWVALID_S[s]                       = 1'b1;
                AWID_S[s*IDS_BITS +: IDS_BITS]     = r_req.id;
                AWADDR_S[s*ADDR_BITS +: ADDR_BITS] = r_req.addr;
                AWLEN_S[s*LEN_BITS +: LEN_BITS]    = r_req.len;
                AWSIZE_S[s*SIZE_BITS +: SIZE_BITS] = r_req.size;
                AWBURST_S[s*2 +: 2]                = r_req.burst;
            end else begin
                AWVALID_S[s] = 1'b0;
            end
        end
    end

    assign w_aw_hs = |(AWVALID_S & AWREADY_S);

    // Transaction FSM: IDLE -> ADDR -> DATA -> RESP, holding the path until B.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state   <= IDLE;
            r_ptr     <= MI_BITS'(NUM_M - 1);
            r_mst     <= '0;
            r_slv     <= '0;
            r_awvalid <= 1'b0;
            r_req     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req.id    <= {TAGW'(w_gnt_idx), w_sel_id};
                        r_req.addr  <= w_sel_addr;
                        r_req.len   <= w_sel_len;
                        r_req.size  <= w_sel_size;
                        r_req.burst <= w_sel_burst;
                        r_mst       <= w_gnt_idx;
                        r_slv       <= w_dec;
                        r_ptr       <= w_gnt_idx;
                        r_awvalid   <= 1'b1;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (wlast_hs) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_awvalid <= 1'b0;
                end
            endcase
        end
    end

    assign wr_busy = (r_state != IDLE);
    assign w_mst   = r_mst;
    assign w_slv   = r_slv;

endmodule

// File: tb/tb_axi_aw_router.sv
// Directed self-checking bench for axi_aw_router (2 masters, 5 slaves).
module tb_axi_aw_router;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [7:0]   AWID_M = '0;
    logic [63:0]  AWADDR_M = '0;
    logic [7:0]   AWLEN_M = '0;
    logic [5:0]   AWSIZE_M = '0;
    logic [3:0]   AWBURST_M = '0;
    logic [1:0]   AWVALID_M = '0;
    logic [1:0]   AWREADY_M;
    logic [39:0]  AWID_S;
    logic [159:0] AWADDR_S;
    logic [19:0]  AWLEN_S;
    logic [14:0]  AWSIZE_S;
    logic [9:0]   AWBURST_S;
    logic [4:0]   AWVALID_S;
    logic [4:0]   AWREADY_S = '0;
    logic         wlast_hs = 1'b0;
    logic         b_hs = 1'b0;
    logic         wr_busy;
    logic [0:0]   w_mst;
    logic [2:0]   w_slv;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axi_aw_router dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWID_M    (AWID_M),
        .AWADDR_M  (AWADDR_M),
        .AWLEN_M   (AWLEN_M),
        .AWSIZE_M  (AWSIZE_M),
        .AWBURST_M (AWBURST_M),
        .AWVALID_M (AWVALID_M),
        .AWREADY_M (AWREADY_M),
        .AWID_S    (AWID_S),
        .AWADDR_S  (AWADDR_S),
        .AWLEN_S   (AWLEN_S),
        .AWSIZE_S  (AWSIZE_S),
        .AWBURST_S (AWBURST_S),
        .AWVALID_S (AWVALID_S),
        .AWREADY_S (AWREADY_S),
        .wlast_hs  (wlast_hs),
        .b_hs      (b_hs),
        .wr_busy   (wr_busy),
        .w_mst     (w_mst),
        .w_slv     (w_slv)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_m(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        AWID_M[m*4 +: 4]     = id;
        AWADDR_M[m*32 +: 32] = addr;
        AWLEN_M[m*4 +: 4]    = len;
        AWSIZE_M[m*3 +: 3]   = size;
        AWBURST_M[m*2 +: 2]  = burst;
    endtask

    task automatic finish_wb();
        wlast_hs = 1'b1;
        step();
        wlast_hs = 1'b0;
        b_hs = 1'b1;
        step();
        b_hs = 1'b0;
    endtask

    initial begin
        int          exp_m;
        logic [1:0]  exp_rdy;

        // Reset with a request pending: nothing may be accepted.
        AWVALID_M = 2'b01;
        set_m(0, 4'h5, 32'h1000_0000, 4'h3, 3'h2, 2'h1);
        step();
        step();
        check("rst_awready", 64'(AWREADY_M), 64'h0);
        check("rst_busy", 64'(wr_busy), 64'h0);
        check("rst_awvalid_s", 64'(AWVALID_S), 64'h0);
        check("rst_w_mst", 64'(w_mst), 64'h0);
        check("rst_w_slv", 64'(w_slv), 64'h0);

        // Single request from M0 to slave 1.
        ARESETn = 1'b1;
        #1;
        check("t1_awready", 64'(AWREADY_M), 64'h1);
        step();
        AWVALID_M = 2'b00;
        AWREADY_S = 5'b11111;
        #1;
        check("t1_awvalid_s", 64'(AWVALID_S), 64'h02);
        check("t1_awid_s1", 64'(AWID_S[15:8]), 64'h05);
        check("t1_awaddr_s1", 64'(AWADDR_S[63:32]), 64'h1000_0000);
        check("t1_awlen_s1", 64'(AWLEN_S[7:4]), 64'h3);
        check("t1_w_slv", 64'(w_slv), 64'h1);
        check("t1_busy", 64'(wr_busy), 64'h1);
        check("t1_awready_off", 64'(AWREADY_M), 64'h0);
        step();
        check("t1_data_valid", 64'(AWVALID_S), 64'h0);
        finish_wb();
        check("t1_idle", 64'(wr_busy), 64'h0);

        // Both masters request continuously with zero-wait slave, W and B.
        set_m(0, 4'h1, 32'h2000_0000, 4'h0, 3'h2, 2'h1);
        set_m(1, 4'hA, 32'h4000_1234, 4'h7, 3'h3, 2'h2);
        AWVALID_M = 2'b11;
        wlast_hs  = 1'b1;
        b_hs      = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            exp_m   = ((k / 4) % 2 == 0) ? 1 : 0;
            exp_rdy = 2'b01 << exp_m;
            if (k % 4 == 0) begin
                check("rr_grant", 64'(AWREADY_M), 64'(exp_rdy));
            end else begin
                check("rr_no_grant", 64'(AWREADY_M), 64'h0);
            end
            if (k % 4 == 1) begin
                check("rr_w_mst", 64'(w_mst), 64'(exp_m));
                if (exp_m == 1) begin
                    check("rr_valid_m1", 64'(AWVALID_S), 64'h08);
                    check("rr_id_m1", 64'(AWID_S[31:24]), 64'h1A);
                end else begin
                    check("rr_valid_m0", 64'(AWVALID_S), 64'h04);
                    check("rr_id_m0", 64'(AWID_S[23:16]), 64'h01);
                end
            end
            step();
        end
        AWVALID_M = 2'b00;
        wlast_hs  = 1'b0;
        b_hs      = 1'b0;
        check("rr_idle", 64'(wr_busy), 64'h0);

        // Slave stalls 3 cycles; WLAST seen in ADDR and on the AW handshake is ignored.
        set_m(0, 4'h2, 32'h0000_0040, 4'hF, 3'h1, 2'h1);
        AWVALID_M = 2'b01;
        AWREADY_S = 5'b00000;
        #1;
        check("st_awready", 64'(AWREADY_M), 64'h1);
        step();
        AWVALID_M = 2'b00;
        wlast_hs  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_valid", 64'(AWVALID_S), 64'h01);
            check("st_addr", 64'(AWADDR_S[31:0]), 64'h40);
            check("st_id", 64'(AWID_S[7:0]), 64'h02);
            check("st_len", 64'(AWLEN_S[3:0]), 64'hF);
            step();
        end
        AWREADY_S = 5'b00001;
        #1;
        check("st_valid_hs", 64'(AWVALID_S), 64'h01);
        step();
        AWREADY_S = 5'b00000;
        wlast_hs  = 1'b0;
        b_hs      = 1'b1;
        #1;
        check("st_data_valid", 64'(AWVALID_S), 64'h0);
        check("st_data_busy", 64'(wr_busy), 64'h1);
        step();
        check("st_still_data", 64'(wr_busy), 64'h1);
        b_hs     = 1'b0;
        wlast_hs = 1'b1;
        step();
        wlast_hs = 1'b0;
        check("st_resp_busy", 64'(wr_busy), 64'h1);
        b_hs = 1'b1;
        step();
        b_hs = 1'b0;
        check("st_idle", 64'(wr_busy), 64'h0);

        // Decode miss routes to the default slave.
        set_m(1, 4'h3, 32'hDEAD_0000, 4'h1, 3'h2, 2'h1);
        AWVALID_M = 2'b10;
        AWREADY_S = 5'b11111;
        #1;
        check("df_awready", 64'(AWREADY_M), 64'h2);
        step();
        AWVALID_M = 2'b00;
        #1;
        check("df_w_slv", 64'(w_slv), 64'h4);
        check("df_w_mst", 64'(w_mst), 64'h1);
        check("df_valid", 64'(AWVALID_S), 64'h10);
        check("df_id", 64'(AWID_S[39:32]), 64'h13);
        check("df_addr", 64'(AWADDR_S[159:128]), 64'hDEAD_0000);
        check("df_others_zero", 64'(AWADDR_S[127:0] == 128'h0), 64'h1);
        step();
        finish_wb();
        check("df_idle", 64'(wr_busy), 64'h0);

        // Reset during DATA, then a lone M1 request is taken immediately.
        set_m(0, 4'h6, 32'h1000_0010, 4'h2, 3'h2, 2'h1);
        AWVALID_M = 2'b01;
        #1;
        check("rd_awready", 64'(AWREADY_M), 64'h1);
        step();
        AWVALID_M = 2'b00;
        step();
        check("rd_busy_data", 64'(wr_busy), 64'h1);
        ARESETn   = 1'b0;
        AWVALID_M = 2'b10;
        set_m(1, 4'h9, 32'h2000_0100, 4'h0, 3'h2, 2'h1);
        #1;
        check("rd_awready_rst", 64'(AWREADY_M), 64'h0);
        step();
        ARESETn = 1'b1;
        #1;
        check("rd_busy", 64'(wr_busy), 64'h0);
        check("rd_valid", 64'(AWVALID_S), 64'h0);
        check("rd_w_mst", 64'(w_mst), 64'h0);
        check("rd_w_slv", 64'(w_slv), 64'h0);
        check("rd_grant_m1", 64'(AWREADY_M), 64'h2);
        step();
        AWVALID_M = 2'b00;
        #1;
        check("rd_valid_s2", 64'(AWVALID_S), 64'h04);
        check("rd_mst1", 64'(w_mst), 64'h1);
        check("rd_id_s2", 64'(AWID_S[23:16]), 64'h19);
        step();
        finish_wb();
        check("rd_idle", 64'(wr_busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
